pwm_multichannel: RTL
=====================

# pwm_multichannel

Parametrised multi-channel PWM generator, the successor to the fixed 16-channel, 8-bit peripheral behind the chip's uo_out/uio_out pins. It drives NUM_CH outputs from one shared period counter. Each channel has its own shadowed duty register. A clock prescaler and an edge- or center-aligned counting mode are selectable. Duty, prescale and mode updates take effect only at period boundaries, so outputs never glitch. It sits between the register file (SPI-written configuration) and the top-level output pins.

## Interface

Parameters:
- NUM_CH, 16, number of PWM channels (1..32)
- RES_BITS, 8, duty/counter resolution in bits (2..16); MAX = 2^RES_BITS - 1
- PRESCALE_BITS, 8, width of prescale divider

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en_out  in  NUM_CH  per-channel output enable
- en_pwm  in  NUM_CH  per-channel PWM enable (0 = static high when output enabled)
- duty_wr_en  in  1  one-cycle write strobe for a shadow duty register
- duty_wr_ch  in  max(1,$clog2(NUM_CH))  channel index for write
- duty_wr_data  in  RES_BITS  duty value
- prescale  in  PRESCALE_BITS  tick divider; tick every prescale+1 clk cycles
- mode  in  1  0 = edge-aligned, 1 = center-aligned
- out  out  NUM_CH  registered PWM outputs
- period_start  out  1  one-cycle pulse at the start of each period

## Operation

- Reset (asynchronous, rst_n low): pre_cnt=0, cnt=0, dir=up, all shadow and active duty=0, active prescale=0, active mode=0, out=0, period_start=0.
- Shadow write: when duty_wr_en=1, shadow[duty_wr_ch] <= duty_wr_data on that clock edge. An index >= NUM_CH is ignored. A later write before the boundary overwrites the earlier one.
- Prescaler: tick=1 when pre_cnt == active prescale. pre_cnt resets to 0 on tick, else increments.
- Edge mode: on each tick, cnt goes 0,1,...,MAX, then wraps to 0. One period is MAX+1 ticks.
- Center mode: on each tick, cnt goes 0,1,...,MAX-1, then MAX-1,...,1,0. Each endpoint is held for two ticks, and the direction flips on the repeat. One period is 2*MAX ticks.
- Period boundary: the tick on which cnt is at the last state of the period. Edge mode: cnt=MAX. Center mode: cnt=0 with dir=down. On that tick:
  - all shadow duties copy into active duties;
  - the prescale and mode inputs are latched;
  - cnt <= 0 and dir <= up.
- Per-channel output, computed combinationally and then registered into out:
  - en_out=0: 0.
  - en_out=1, en_pwm=0: 1.
  - en_out=1, en_pwm=1: 1 if active_duty==MAX, else (cnt < active_duty).
  - duty 0 gives constant 0; duty MAX gives constant 1 in both modes.
- Center mode high time is 2*duty ticks, symmetric about the period boundary.
- en_out and en_pwm are not shadowed. They act on the next clock edge.

## Timing

- out reflects (cnt, active_duty, en_*) with one clk of latency.
- period_start is registered: it is high for exactly one clk, in the cycle after the boundary edge, coincident with out showing cnt=0 of the new period.
- Edge mode, prescale P: period = (MAX+1)*(P+1) clk cycles and high time = duty*(P+1) clk cycles.
- Center mode, prescale P: period = 2*MAX*(P+1) clk cycles and high time = 2*duty*(P+1) clk cycles.
- Duty write to first effect: at most one full period plus one clk. A write in the same cycle as the boundary tick misses that boundary and applies at the next one.
- A prescale or mode change mid-period is invisible until the boundary. The current period finishes with the old settings.
- Reset deasserted mid-period: the block restarts from cnt=0. The first period uses prescale=0, mode=0 and duty 0 until the first boundary.
- No arithmetic overflow: the compare is unsigned at RES_BITS, and pre_cnt is PRESCALE_BITS wide.

## Test plan

- Reset: assert rst_n=0 mid-run, asynchronously between clock edges -> out=0 and period_start=0 immediately; after release, first period_start comes 256 clks later (8-bit, prescale latched 0).
- Edge mode, 8-bit, prescale 0, channel 0 duty written to 0 / 64 / 255 -> over each 256-clk period, high 0 / 64 / 256 clks; period_start spacing 256 clks.
- Shadow timing: write duty 200 at cnt=10 while active duty is 50 -> current period stays high 50 clks; next period high 200 clks; no runt pulse.
- Prescale 3 written mid-period -> current period remains 256 clks; following periods are 1024 clks with duty 64 high for 256 clks.
- Center mode, 8-bit, prescale 0, duty 64 -> period 510 clks; out high for the first 64 and last 64 clks of each period; duty 255 -> constant high.
- Gating and edge cases, channel 5 duty 128:
  - en_out=0 -> 0 regardless of duty;
  - en_out=1, en_pwm=0 -> constant 1 on the next clk;
  - write to index NUM_CH -> no channel changes.

Source files
------------

// File: rtl/pwm_multichannel_if.sv
// pwm_multichannel_if: PWM configuration/output bundle; master drives enables, duty writes, prescale, mode and receives out, period_start
interface pwm_multichannel_if #(
  parameter int NUM_CH = 16,
  parameter int RES_BITS = 8,
  parameter int PRESCALE_BITS = 8
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic duty_wr_en;
  logic [CH_W-1:0] duty_wr_ch;
  logic [RES_BITS-1:0] duty_wr_data;
  logic [PRESCALE_BITS-1:0] prescale;
  logic mode;
  logic [NUM_CH-1:0] out;
  logic period_start;
  modport master (
    output en_out, en_pwm, duty_wr_en, duty_wr_ch, duty_wr_data, prescale, mode,
    input out, period_start
  );
  modport slave (
    input en_out, en_pwm, duty_wr_en, duty_wr_ch, duty_wr_data, prescale, mode,
    output out, period_start
  );
endinterface

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH PWM outputs from one shared counter with shadowed duty, prescale and edge/center mode applied at period boundaries; ports clk, rst_n, bus (enables, duty write, prescale, mode in; out, period_start out)
module pwm_multichannel #(
  parameter int NUM_CH = 16,
  parameter int RES_BITS = 8,
  parameter int PRESCALE_BITS = 8
) (
  input logic clk,
  input logic rst_n,
  pwm_multichannel_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [RES_BITS-1:0] MAX = '1;
  localparam logic [RES_BITS-1:0] ONE = RES_BITS'(1);
  localparam logic [RES_BITS-1:0] TOP = MAX - ONE;
  localparam logic [PRESCALE_BITS-1:0] PONE = PRESCALE_BITS'(1);
  logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d, act_pre_q, act_pre_d;
  logic [RES_BITS-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, act_mode_q, act_mode_d, bnd_q, bnd_d, ps_q, ps_d;
  logic [RES_BITS-1:0] shadow_q [NUM_CH];
  logic [RES_BITS-1:0] shadow_d [NUM_CH];
  logic [RES_BITS-1:0] active_q [NUM_CH];
  logic [RES_BITS-1:0] active_d [NUM_CH];
  logic [NUM_CH-1:0] out_q, out_d;
  logic tick, bnd, turn;
  always_comb begin
    tick = pre_cnt_q == act_pre_q;
    bnd = tick && (act_mode_q ? (cnt_q == '0 && dir_q) : cnt_q == MAX);
    turn = tick && act_mode_q && !dir_q && cnt_q == TOP;
    pre_cnt_d = tick ? '0 : pre_cnt_q + PONE;
    cnt_d = bnd ? '0 : !tick || turn ? cnt_q : act_mode_q && dir_q ? cnt_q - ONE : cnt_q + ONE;
    dir_d = bnd ? 1'b0 : turn ? 1'b1 : dir_q;
    act_pre_d = bnd ? bus.prescale : act_pre_q;
    act_mode_d = bnd ? bus.mode : act_mode_q;
    bnd_d = bnd;
    ps_d = bnd_q;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = bus.duty_wr_en && bus.duty_wr_ch == CH_W'(i) ? bus.duty_wr_data : shadow_q[i];
      active_d[i] = bnd ? shadow_q[i] : active_q[i];
      out_d[i] = bus.en_out[i] && (!bus.en_pwm[i] || active_q[i] == MAX || cnt_q < active_q[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
      act_pre_q <= '0;
      act_mode_q <= 1'b0;
      bnd_q <= 1'b0;
      ps_q <= 1'b0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      out_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      act_pre_q <= act_pre_d;
      act_mode_q <= act_mode_d;
      bnd_q <= bnd_d;
      ps_q <= ps_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      out_q <= out_d;
    end
  end
  assign bus.out = out_q;
  assign bus.period_start = ps_q;
endmodule
